reflet_boot_loader: RTL and testbench
=====================================

Name: reflet_boot_loader

Overview:
- Parametrised boot and reset sequencer for reflet controllers of any word size.
- Holds the CPU in reset for a fixed number of cycles.
- Copies a boot image from a synchronous ROM into instruction RAM over the system bus, then releases the CPU and hands the bus over to it.
- Sits between the CPU bus master port and the memory map. It replaces the fixed power-on blink and the "replace RAM with ROM" approach with a generic ROM-to-RAM copy.

Parameters:
- wordsize, 16, data and address width of the system bus (8/16/32/64)
- boot_len, 64, number of words copied; must be >= 1
- rom_addr_size, 8, ROM address width; must satisfy 2^rom_addr_size >= boot_len+1
- boot_base, 0, bus address of the first destination word
- reset_cycles, 4, CPU reset hold length in cycles; must be >= 1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; restarts the whole sequence
- soft_reboot  in  1  one-cycle pulse; requests a re-copy and CPU restart
- cpu_addr  in  wordsize  CPU bus address
- cpu_data_out  in  wordsize  CPU write data
- cpu_write_en  in  1  CPU write strobe
- rom_addr  out  rom_addr_size  ROM read address
- rom_data  in  wordsize  ROM data, valid one cycle after rom_addr
- bus_addr  out  wordsize  address to the memory map
- bus_data  out  wordsize  write data to the memory map
- bus_we  out  1  write strobe to the memory map
- cpu_reset  out  1  active-high CPU reset
- busy  out  1  high while the loader owns the bus
- fault  out  1  checksum failure, only with the optional feature

Behaviour:

Reset values (while reset=1):
- state=HOLD, counter=0
- cpu_reset=1, busy=1, fault=0
- bus_we=0, bus_addr=0, bus_data=0, rom_addr=0
- State registers and the write pipeline register reset asynchronously.

States: HOLD -> COPY -> DRAIN -> RUN, plus FAULT (optional feature only).

HOLD:
- Stays for reset_cycles cycles, then goes to COPY with counter=0.
- cpu_reset=1, busy=1, bus_we=0.

COPY:
- In each cycle, with counter=k, drive rom_addr=k and increment counter.
- A one-stage pipeline registers a valid flag and the destination address.
- In the next cycle, drive bus_addr=boot_base+k (modulo 2^wordsize, wraps), bus_data=rom_data and bus_we=1.
- When k=boot_len-1 has been issued, go to DRAIN.

DRAIN:
- Lasts one cycle and performs the final write (index boot_len-1).
- Then goes to RUN.

Timing from reset release:
- Cycles 0..R-1: HOLD.
- Reads issued in cycles R..R+L-1.
- Writes in cycles R+1..R+L.
- cpu_reset falls at cycle R+L+1.
- Here R=reset_cycles and L=boot_len.

RUN:
- cpu_reset=0, busy=0, combinational pass-through: bus_addr=cpu_addr, bus_data=cpu_data_out, bus_we=cpu_write_en.
- rom_addr is held at 0.

While busy=1:
- cpu_write_en is ignored; the CPU is in reset.

soft_reboot:
- Honoured only in RUN: the next cycle enters HOLD, cpu_reset=1, and the full sequence repeats.
- Ignored in HOLD, COPY, DRAIN and FAULT.

Mid-operation reset:
- reset asserted at any point aborts immediately; no partial write is issued after assertion.
- Deassertion restarts from HOLD.

Optional Feature:

Macro: REFLET_BOOT_CHECKSUM_EN

Defined:
- The loader additionally reads ROM word boot_len in the cycle after the last copy read; that word is not written to the bus.
- It accumulates a wordsize-bit wrapping sum of words 0..boot_len.
- DRAIN lasts 2 cycles (last write, then checksum compare).
- Sum == 0: go to RUN. Release is at cycle R+L+2.
- Sum != 0: go to FAULT: fault=1, cpu_reset=1, busy=1, bus_we=0. Only reset exits FAULT; soft_reboot is ignored.

Undefined:
- No checksum word is read, fault is tied to 0, and FAULT is unreachable.

Test Plan:
1. wordsize=16, boot_len=4, reset_cycles=4, boot_base=0, ROM={0x1111,0x2222,0x3333,0x4444}, release reset -> bus_we=1 in cycles 5..8 with addr 0..3 and matching data; cpu_reset falls at cycle 9; busy=0 from cycle 9.
2. In RUN, drive cpu_addr=0x8004, cpu_data_out=0xBEEF, cpu_write_en=1 -> same values on bus_* in the same cycle; pulse soft_reboot -> cpu_reset=1 next cycle and the copy repeats with identical writes.
3. Assert reset in cycle 6 (mid-copy) -> bus_we drops immediately, cpu_reset stays 1; release -> full sequence restarts from HOLD, with 4 writes from addr 0.
4. boot_base=0xFFFE, boot_len=4 -> writes go to 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
5. soft_reboot pulsed during COPY -> ignored; exactly boot_len writes; single release.
6. With REFLET_BOOT_CHECKSUM_EN: ROM word 4=0x5556 (sum 0) -> RUN at cycle 10, fault=0. ROM word 4=0x0000 -> FAULT, fault=1, cpu_reset held, 4 writes only.

Source files
------------

// File: rtl/reflet_boot_loader.sv
// reflet_boot_loader: holds the CPU in reset, copies a boot image from ROM to RAM, then hands over the bus.
// Optional checksum verification of the image is enabled with REFLET_BOOT_CHECKSUM_EN.
module reflet_boot_loader #(
    parameter int wordsize = 16,
    parameter int boot_len = 64,
    parameter int rom_addr_size = 8,
    parameter longint unsigned boot_base = 0,
    parameter int reset_cycles = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     soft_reboot,
    input  logic [wordsize-1:0]      cpu_addr,
    input  logic [wordsize-1:0]      cpu_data_out,
    input  logic                     cpu_write_en,
    output logic [rom_addr_size-1:0] rom_addr,
    input  logic [wordsize-1:0]      rom_data,
    output logic [wordsize-1:0]      bus_addr,
    output logic [wordsize-1:0]      bus_data,
    output logic                     bus_we,
    output logic                     cpu_reset,
    output logic                     busy,
    output logic                     fault
);
    localparam int hold_w = $clog2(reset_cycles + 1);
    localparam int cw = rom_addr_size > hold_w ? rom_addr_size : hold_w;
    typedef enum logic [2:0] {HOLD, COPY, DRAIN, RUN, FAULT} state_t;
    state_t state, state_n;
    logic [cw-1:0] counter;
    logic wr_valid;
    logic [wordsize-1:0] wr_addr;
`ifdef REFLET_BOOT_CHECKSUM_EN
    logic [wordsize-1:0] sum;
`endif
    // The write stage trails the ROM read by one cycle to match the synchronous ROM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HOLD;
            counter <= '0;
            wr_valid <= 1'b0;
            wr_addr <= '0;
`ifdef REFLET_BOOT_CHECKSUM_EN
            sum <= '0;
`endif
        end else begin
            state <= state_n;
            counter <= (state == RUN || (state == HOLD && state_n != HOLD)) ? '0 : counter + 1'b1;
            wr_valid <= state == COPY;
            wr_addr <= wordsize'(boot_base) + wordsize'(counter);
`ifdef REFLET_BOOT_CHECKSUM_EN
            sum <= state == HOLD ? '0 : wr_valid ? sum + rom_data : sum;
`endif
        end
    end
    always_comb begin
        state_n = state;
        cpu_reset = 1'b1;
        busy = 1'b1;
        fault = 1'b0;
        rom_addr = '0;
        bus_we = wr_valid;
        bus_addr = wr_valid ? wr_addr : '0;
        bus_data = wr_valid ? rom_data : '0;
        case (state)
            HOLD: state_n = counter == cw'(reset_cycles - 1) ? COPY : HOLD;
            COPY: begin
                rom_addr = counter[rom_addr_size-1:0];
                state_n = counter == cw'(boot_len - 1) ? DRAIN : COPY;
            end
`ifdef REFLET_BOOT_CHECKSUM_EN
            // First drain cycle fetches the checksum word, second one judges the total.
            DRAIN: begin
                rom_addr = counter[rom_addr_size-1:0];
                state_n = counter == cw'(boot_len) ? DRAIN : (sum + rom_data == '0 ? RUN : FAULT);
            end
            FAULT: fault = 1'b1;
`else
            DRAIN: state_n = RUN;
`endif
            RUN: begin
                cpu_reset = 1'b0;
                busy = 1'b0;
                bus_we = cpu_write_en;
                bus_addr = cpu_addr;
                bus_data = cpu_data_out;
                state_n = soft_reboot ? HOLD : RUN;
            end
            default: state_n = HOLD;
        endcase
    end
endmodule

// File: tb/tb_reflet_boot_loader.sv
// tb_reflet_boot_loader: scoreboard bench for the boot loader with a wrapping boot_base.
module tb_reflet_boot_loader;
    localparam int W = 16;
    localparam int L = 4;
    localparam int RA = 8;
    localparam int R = 4;
    localparam longint unsigned BASE = 64'hFFFE;
    localparam int INF = 32'h7fffffff;

    logic clk = 0, reset = 0, soft_reboot = 0, cpu_write_en = 0;
    logic [W-1:0] cpu_addr = '0, cpu_data_out = '0, rom_data, bus_addr, bus_data;
    logic [RA-1:0] rom_addr;
    logic bus_we, cpu_reset, busy, fault;
    logic [W-1:0] rom [2**RA];
    int cyc = 0, run_from = INF, fault_from = INF, vectors = 0, errors = 0;
    typedef struct {int c; logic [W-1:0] a; logic [W-1:0] d;} wr_t;
    wr_t q[$];

    reflet_boot_loader #(.wordsize(W), .boot_len(L), .rom_addr_size(RA), .boot_base(BASE), .reset_cycles(R)) dut (
        .clk(clk), .reset(reset), .soft_reboot(soft_reboot), .cpu_addr(cpu_addr),
        .cpu_data_out(cpu_data_out), .cpu_write_en(cpu_write_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
        .cpu_reset(cpu_reset), .busy(busy), .fault(fault));

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // bad=1 makes the image checksum nonzero
    task automatic fill_rom(input bit bad);
        logic [W-1:0] s = '0;
        for (int i = 0; i < 2**RA; i++) rom[i] = W'($urandom);
        for (int k = 0; k < L; k++) s += rom[k];
        rom[L] = bad ? W'(0) - s + W'($urandom_range(1, 16'hFFFF)) : W'(0) - s;
    endtask

    // Reference: sequence whose cycle 0 is absolute cycle s
    task automatic start_seq(input int s);
        logic [W-1:0] sum = '0;
        for (int k = 0; k <= L; k++) sum += rom[k];
        for (int k = 0; k < L; k++) q.push_back('{s + R + 1 + k, W'(BASE + 64'(k)), rom[k]});
        fault_from = INF;
`ifdef REFLET_BOOT_CHECKSUM_EN
        if (sum == '0) run_from = s + R + L + 2;
        else begin
            run_from = INF;
            fault_from = s + R + L + 2;
        end
`else
        run_from = s + R + L + 1;
`endif
    endtask

    task automatic cpu_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_addr = W'($urandom);
            cpu_data_out = W'($urandom);
            cpu_write_en = 1'($urandom);
            if (cpu_write_en) q.push_back('{cyc, cpu_addr, cpu_data_out});
            tick;
        end
        cpu_write_en = 0;
    endtask

    task automatic reboot;
        soft_reboot = 1;
        tick;
        soft_reboot = 0;
        start_seq(cyc);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (reset) begin
            check("rst_cpu_reset", cpu_reset, 1);
            check("rst_busy", busy, 1);
            check("rst_fault", fault, 0);
            check("rst_bus_we", bus_we, 0);
            check("rst_bus_addr", bus_addr, 0);
            check("rst_bus_data", bus_data, 0);
            check("rst_rom_addr", rom_addr, 0);
        end else begin
            check("cpu_reset", cpu_reset, cyc < run_from);
            check("busy", busy, cyc < run_from);
            check("fault", fault, cyc >= fault_from);
            while (q.size() > 0 && q[0].c < cyc) begin
                vectors++;
                errors++;
                $display("FAIL missed_write: got none expected addr %0h at cycle %0d", q[0].a, q[0].c);
                void'(q.pop_front());
            end
            if (bus_we) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h expected no write at cycle %0d", bus_addr, cyc);
                end else begin
                    e = q.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(e.c));
                    check("wr_addr", bus_addr, e.a);
                    check("wr_data", bus_data, e.d);
                end
            end
        end
    end

    initial begin
        int s;
        fill_rom(0);
        #1 reset = 1;
        repeat (3) tick;
        reset = 0;
        start_seq(cyc);
        while (cyc < run_from) tick;
        cpu_addr = 16'h8004;
        cpu_data_out = 16'hBEEF;
        cpu_write_en = 1;
        q.push_back('{cyc, 16'h8004, 16'hBEEF});
        tick;
        cpu_traffic(8);
        // Reboots with CPU writes and a stray soft_reboot during the copy
        for (int it = 0; it < 4; it++) begin
            fill_rom(0);
            reboot;
            s = cyc;
            while (cyc < run_from && cyc < s + 100) begin
                cpu_addr = W'($urandom);
                cpu_data_out = W'($urandom);
                cpu_write_en = 1;
                soft_reboot = cyc == s + R + 1;
                tick;
            end
            soft_reboot = 0;
            cpu_write_en = 0;
            cpu_traffic(6);
        end
        // Reset in the middle of the copy
        reboot;
        s = cyc;
        while (cyc < s + R + 2) tick;
        #2 reset = 1;
        q.delete();
        #1;
        check("abort_bus_we", bus_we, 0);
        check("abort_cpu_reset", cpu_reset, 1);
        check("abort_busy", busy, 1);
        repeat (3) tick;
        reset = 0;
        start_seq(cyc);
        while (cyc < run_from) tick;
        cpu_traffic(5);
`ifdef REFLET_BOOT_CHECKSUM_EN
        fill_rom(1);
        reboot;
        s = cyc;
        while (cyc < s + R + L + 5) tick;
        soft_reboot = 1;
        tick;
        soft_reboot = 0;
        repeat (4) tick;
        reset = 1;
        repeat (2) tick;
        reset = 0;
        fill_rom(0);
        start_seq(cyc);
        while (cyc < run_from) tick;
        cpu_traffic(4);
`endif
        repeat (2) tick;
        check("queue_empty", 64'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
